led_channel_calibrator: RTL and testbench

- Parametrised successor to the two-LED pulse-oximeter front-end controller.
- Calibrates NUM_CH LED channels in sequence. For each channel it searches a DC-compensation code, then the largest non-clipping PGA gain, and stores both per channel.
- After calibration it time-multiplexes the LEDs round-robin, applies each channel's stored settings, and streams one tagged ADC sample per slot.
- Sits between the ADC/AFE pins and the downstream SpO2 processing.

---
 rtl/led_channel_calibrator_pkg.sv | 33 +++
 rtl/led_channel_calibrator_if.sv | 43 ++++
 rtl/led_channel_calibrator_window_minmax.sv | 48 ++++
 rtl/led_channel_calibrator.sv | 239 +++++++++++++++++++++++
 tb/tb_led_channel_calibrator.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/led_channel_calibrator_pkg.sv
// led_cal_pkg: shared types and default constants for the LED channel calibrator.
//   cal_state_e  - calibration / operation FSM states
//   DEF_*        - default widths, windows and thresholds
//   clog2_min1() - channel-index width, never below one bit
package led_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DC_SEARCH  = 3'd1,
    ST_PGA_SEARCH = 3'd2,
    ST_NEXT_CH    = 3'd3,
    ST_OPERATION  = 3'd4
  } cal_state_e;

  localparam int DEF_ADC_W      = 8;
  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_DC_W       = 7;
  localparam int DEF_PGA_W      = 4;
  localparam int DEF_DC_INIT    = 64;
  localparam int DEF_DC_WIN     = 10;
  localparam int DEF_PGA_WIN    = 50;
  localparam int DEF_DC_LO      = 110;
  localparam int DEF_DC_HI      = 140;
  localparam int DEF_CLIP_LO    = 5;
  localparam int DEF_CLIP_HI    = 250;
  localparam int DEF_SLOT_LEN   = 10;
  localparam int DEF_DRIVE_INIT = 10;

  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_channel_calibrator_if.sv
// led_cal_if: AFE-side bundle of the LED channel calibrator.
//   Inputs to the calibrator : ADC, Find_setting
//   Outputs of the calibrator: LED_EN, LED_DRIVE, DC_Comp, PGA_Gain, CLK_Filter,
//                              Settings_Valid, Cal_Error, Sample_Valid,
//                              Sample_Data, Sample_Ch
//   slave  - the calibrator's view
//   master - the AFE / host view (drives ADC and Find_setting)
interface led_cal_if
  import led_cal_pkg::*;
#(
  parameter int ADC_W  = DEF_ADC_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DC_W   = DEF_DC_W,
  parameter int PGA_W  = DEF_PGA_W
);
  localparam int CH_W = clog2_min1(NUM_CH);

  logic [ADC_W-1:0]  ADC;
  logic              Find_setting;
  logic [NUM_CH-1:0] LED_EN;
  logic [3:0]        LED_DRIVE;
  logic [DC_W-1:0]   DC_Comp;
  logic [PGA_W-1:0]  PGA_Gain;
  logic              CLK_Filter;
  logic              Settings_Valid;
  logic [NUM_CH-1:0] Cal_Error;
  logic              Sample_Valid;
  logic [ADC_W-1:0]  Sample_Data;
  logic [CH_W-1:0]   Sample_Ch;

  modport slave (
    input  ADC, Find_setting,
    output LED_EN, LED_DRIVE, DC_Comp, PGA_Gain, CLK_Filter, Settings_Valid,
           Cal_Error, Sample_Valid, Sample_Data, Sample_Ch
  );

  modport master (
    output ADC, Find_setting,
    input  LED_EN, LED_DRIVE, DC_Comp, PGA_Gain, CLK_Filter, Settings_Valid,
           Cal_Error, Sample_Valid, Sample_Data, Sample_Ch
  );

endinterface

// File: rtl/led_channel_calibrator_window_minmax.sv
// window_minmax: min/max tracker over a window of len_i samples.
//   CLK, rst_n - clock, async active-low reset
//   clr_i      - hold the window empty (count 0, min all-ones, max 0)
//   len_i      - number of sample cycles in the window
//   sample_i   - sample taken on every counting cycle
//   min_o/max_o- running extremes of the current window
//   done_o     - high on the evaluation cycle that follows len_i samples;
//                the window empties itself on that same edge
module window_minmax #(
  parameter  int ADC_W  = 8,
  parameter  int MAXLEN = 50,
  localparam int LEN_W  = $clog2(MAXLEN + 1)
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [ADC_W-1:0] sample_i,
  output logic [ADC_W-1:0] min_o,
  output logic [ADC_W-1:0] max_o,
  output logic             done_o
);

  logic [LEN_W-1:0] cnt_q;
  logic [ADC_W-1:0] min_q;
  logic [ADC_W-1:0] max_q;

  assign done_o = !clr_i && (cnt_q == len_i);
  assign min_o  = min_q;
  assign max_o  = max_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      min_q <= '1;
      max_q <= '0;
    end else if (clr_i || done_o) begin
      cnt_q <= '0;
      min_q <= '1;
      max_q <= '0;
    end else begin
      cnt_q <= cnt_q + LEN_W'(1);
      if (sample_i < min_q) min_q <= sample_i;
      if (sample_i > max_q) max_q <= sample_i;
    end
  end

endmodule

// File: rtl/led_channel_calibrator.sv
// led_channel_calibrator: per-channel DC-compensation and PGA-gain search for
// NUM_CH LED channels, followed by round-robin LED slots that stream one tagged
// ADC sample per slot.
//   CLK, rst_n - system clock, async active-low reset
//   bus        - led_cal_if.slave: ADC/Find_setting in, LED/AFE controls and
//                sample stream out
//
//   state         | meaning
//   --------------+------------------------------------------------------------
//   ST_IDLE       | outputs at reset values, waits for Find_setting
//   ST_DC_SEARCH  | step DC_Comp until the window midpoint lands in the band
//   ST_PGA_SEARCH | raise PGA_Gain until a window clips, keep last clean gain
//   ST_NEXT_CH    | one cycle: move to next channel or into operation
//   ST_OPERATION  | round-robin slots with stored settings, sample per slot
module led_channel_calibrator
  import led_cal_pkg::*;
#(
  parameter int ADC_W      = DEF_ADC_W,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DC_W       = DEF_DC_W,
  parameter int PGA_W      = DEF_PGA_W,
  parameter int DC_INIT    = DEF_DC_INIT,
  parameter int DC_WIN     = DEF_DC_WIN,
  parameter int PGA_WIN    = DEF_PGA_WIN,
  parameter int DC_LO      = DEF_DC_LO,
  parameter int DC_HI      = DEF_DC_HI,
  parameter int CLIP_LO    = DEF_CLIP_LO,
  parameter int CLIP_HI    = DEF_CLIP_HI,
  parameter int SLOT_LEN   = DEF_SLOT_LEN,
  parameter int DRIVE_INIT = DEF_DRIVE_INIT
) (
  input  logic       CLK,
  input  logic       rst_n,
  led_cal_if.slave   bus
);

  localparam int CH_W    = clog2_min1(NUM_CH);
  localparam int WIN_MAX = (DC_WIN > PGA_WIN) ? DC_WIN : PGA_WIN;
  localparam int LEN_W   = $clog2(WIN_MAX + 1);
  localparam int SLOT_W  = clog2_min1(SLOT_LEN);

  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);

  cal_state_e        state_q;
  logic [CH_W-1:0]   ch_q;
  logic [SLOT_W-1:0] slot_q;
  logic [DC_W-1:0]   dc_tab_q  [NUM_CH];
  logic [PGA_W-1:0]  pga_tab_q [NUM_CH];
  logic [NUM_CH-1:0] led_en_q;
  logic [3:0]        led_drive_q;
  logic [DC_W-1:0]   dc_q;
  logic [PGA_W-1:0]  pga_q;
  logic              clk_filter_q;
  logic              settings_valid_q;
  logic [NUM_CH-1:0] cal_error_q;
  logic              sample_valid_q;
  logic [ADC_W-1:0]  sample_data_q;
  logic [CH_W-1:0]   sample_ch_q;

  logic              win_clr;
  logic [LEN_W-1:0]  win_len;
  logic [ADC_W-1:0]  win_min;
  logic [ADC_W-1:0]  win_max;
  logic              win_done;
  logic [ADC_W:0]    win_sum;
  logic [ADC_W:0]    win_avg;
  logic              clipped;
  logic [CH_W-1:0]   ch_wrap;

  // The window only runs inside the two search states, so each search always
  // starts from an empty window regardless of what happened before.
  assign win_clr = (state_q != ST_DC_SEARCH) && (state_q != ST_PGA_SEARCH);
  assign win_len = (state_q == ST_PGA_SEARCH) ? LEN_W'(PGA_WIN) : LEN_W'(DC_WIN);

  window_minmax #(
    .ADC_W  (ADC_W),
    .MAXLEN (WIN_MAX)
  ) u_win (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .clr_i    (win_clr),
    .len_i    (win_len),
    .sample_i (bus.ADC),
    .min_o    (win_min),
    .max_o    (win_max),
    .done_o   (win_done)
  );

  // Midpoint kept one bit wider so max+min never wraps.
  assign win_sum = {1'b0, win_max} + {1'b0, win_min};
  assign win_avg = win_sum >> 1;
  assign clipped = (win_min <= ADC_W'(CLIP_LO)) || (win_max >= ADC_W'(CLIP_HI));
  assign ch_wrap = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);

  // Filter clock free-runs; only reset stops it.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) clk_filter_q <= 1'b0;
    else        clk_filter_q <= ~clk_filter_q;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      ch_q             <= '0;
      slot_q           <= '0;
      led_en_q         <= '0;
      led_drive_q      <= 4'(DRIVE_INIT);
      dc_q             <= '0;
      pga_q            <= '0;
      settings_valid_q <= 1'b0;
      cal_error_q      <= '0;
      sample_valid_q   <= 1'b0;
      sample_data_q    <= '0;
      sample_ch_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        dc_tab_q[i]  <= '0;
        pga_tab_q[i] <= '0;
      end
    end else if (!bus.Find_setting) begin
      state_q          <= ST_IDLE;
      ch_q             <= '0;
      slot_q           <= '0;
      led_en_q         <= '0;
      led_drive_q      <= 4'(DRIVE_INIT);
      dc_q             <= '0;
      pga_q            <= '0;
      settings_valid_q <= 1'b0;
      cal_error_q      <= '0;
      sample_valid_q   <= 1'b0;
      sample_data_q    <= '0;
      sample_ch_q      <= '0;
    end else begin
      sample_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_q  <= ST_DC_SEARCH;
          ch_q     <= '0;
          dc_q     <= DC_W'(DC_INIT);
          pga_q    <= '0;
          led_en_q <= NUM_CH'(1);
        end

        ST_DC_SEARCH: begin
          if (win_done) begin
            if (win_avg < (ADC_W+1)'(DC_LO)) begin
              if (dc_q == '0) begin
                cal_error_q[ch_q] <= 1'b1;
                dc_tab_q[ch_q]    <= dc_q;
                pga_q             <= '0;
                state_q           <= ST_PGA_SEARCH;
              end else begin
                dc_q <= dc_q - DC_W'(1);
              end
            end else if (win_avg > (ADC_W+1)'(DC_HI)) begin
              if (dc_q == '1) begin
                cal_error_q[ch_q] <= 1'b1;
                dc_tab_q[ch_q]    <= dc_q;
                pga_q             <= '0;
                state_q           <= ST_PGA_SEARCH;
              end else begin
                dc_q <= dc_q + DC_W'(1);
              end
            end else begin
              dc_tab_q[ch_q] <= dc_q;
              pga_q          <= '0;
              state_q        <= ST_PGA_SEARCH;
            end
          end
        end

        ST_PGA_SEARCH: begin
          if (win_done) begin
            if (!clipped && (pga_q != '1)) begin
              pga_q <= pga_q + PGA_W'(1);
            end else begin
              // Clipped: back off one step; clean at full scale: keep it.
              if (!clipped)           pga_tab_q[ch_q] <= pga_q;
              else if (pga_q == '0)   pga_tab_q[ch_q] <= '0;
              else                    pga_tab_q[ch_q] <= pga_q - PGA_W'(1);
              state_q <= ST_NEXT_CH;
            end
          end
        end

        ST_NEXT_CH: begin
          if (ch_q == CH_LAST) begin
            state_q          <= ST_OPERATION;
            ch_q             <= '0;
            slot_q           <= '0;
            led_en_q         <= NUM_CH'(1);
            led_drive_q      <= 4'(DRIVE_INIT);
            dc_q             <= dc_tab_q[0];
            pga_q            <= pga_tab_q[0];
            settings_valid_q <= 1'b1;
          end else begin
            state_q  <= ST_DC_SEARCH;
            ch_q     <= ch_q + CH_W'(1);
            dc_q     <= DC_W'(DC_INIT);
            pga_q    <= '0;
            led_en_q <= NUM_CH'(1) << (ch_q + CH_W'(1));
          end
        end

        ST_OPERATION: begin
          settings_valid_q <= 1'b1;
          led_drive_q      <= 4'(DRIVE_INIT);
          if (slot_q == SLOT_LAST) begin
            // Capture on the slot's last cycle, before the LED switches.
            sample_valid_q <= 1'b1;
            sample_data_q  <= bus.ADC;
            sample_ch_q    <= ch_q;
            slot_q         <= '0;
            ch_q           <= ch_wrap;
            led_en_q       <= NUM_CH'(1) << ch_wrap;
            dc_q           <= dc_tab_q[ch_wrap];
            pga_q          <= pga_tab_q[ch_wrap];
          end else begin
            slot_q <= slot_q + SLOT_W'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.LED_EN         = led_en_q;
  assign bus.LED_DRIVE      = led_drive_q;
  assign bus.DC_Comp        = dc_q;
  assign bus.PGA_Gain       = pga_q;
  assign bus.CLK_Filter     = clk_filter_q;
  assign bus.Settings_Valid = settings_valid_q;
  assign bus.Cal_Error      = cal_error_q;
  assign bus.Sample_Valid   = sample_valid_q;
  assign bus.Sample_Data    = sample_data_q;
  assign bus.Sample_Ch      = sample_ch_q;

endmodule

// File: tb/tb_led_channel_calibrator.sv
// Directed bench for led_channel_calibrator (NUM_CH=2, default thresholds).
// ADC source modes:
//   0 - constant 125
//   1 - per-LED constants (LED0 -> 30, LED1 -> 200)
//   2 - AFE model: 96 + 2*(64-DC_Comp) + 10*PGA_Gain, +/-4 alternating,
//       clamped to 0..255 (DC settles at 57, gain at 13)
//   3 - constant 0
module tb_led_channel_calibrator;

  logic CLK;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;
  int   mode;
  logic tog;

  led_cal_if #(.ADC_W(8), .NUM_CH(2), .DC_W(7), .PGA_W(4)) bus ();

  led_channel_calibrator #(
    .ADC_W(8), .NUM_CH(2), .DC_W(7), .PGA_W(4)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_adc();
    int v;
    case (mode)
      0: v = 125;
      1: v = (bus.LED_EN == 2'b01) ? 30 : (bus.LED_EN == 2'b10) ? 200 : 0;
      2: begin
        v = 96 + 2 * (64 - int'(bus.DC_Comp)) + 10 * int'(bus.PGA_Gain);
        v = tog ? v + 4 : v - 4;
      end
      default: v = 0;
    endcase
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
    bus.ADC = 8'(v);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    tog = ~tog;
    drive_adc();
  endtask

  // Counts edges from the Find_setting rise until Settings_Valid is seen.
  task automatic wait_op(input int n0, input int exp_edges);
    int n;
    n = n0;
    while (!bus.Settings_Valid && n < 4000) begin
      step();
      n++;
    end
    if (bus.Settings_Valid) chk("cal_edges", n, exp_edges);
    else                    chk("cal_timeout", bus.Settings_Valid, 1);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_led_en"},    bus.LED_EN, 0);
    chk({pfx, "_led_drive"}, bus.LED_DRIVE, 10);
    chk({pfx, "_dc"},        bus.DC_Comp, 0);
    chk({pfx, "_pga"},       bus.PGA_Gain, 0);
    chk({pfx, "_clk_filt"},  bus.CLK_Filter, 0);
    chk({pfx, "_valid"},     bus.Settings_Valid, 0);
    chk({pfx, "_cal_err"},   bus.Cal_Error, 0);
    chk({pfx, "_smp_vld"},   bus.Sample_Valid, 0);
    chk({pfx, "_smp_data"},  bus.Sample_Data, 0);
    chk({pfx, "_smp_ch"},    bus.Sample_Ch, 0);
  endtask

  initial begin
    logic cf0;
    vec_cnt = 0;
    err_cnt = 0;
    mode = 0;
    tog = 1'b0;
    bus.ADC = '0;
    bus.Find_setting = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst");
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;

    // Filter clock runs with Find_setting low.
    step();
    cf0 = bus.CLK_Filter;
    step();
    chk("clk_filt_toggle", bus.CLK_Filter, {31'd0, ~cf0});
    chk("idle_led_en", bus.LED_EN, 0);

    // Constant 125: in band at once, never clips.
    mode = 0;
    drive_adc();
    bus.Find_setting = 1'b1;
    wait_op(0, 1657);
    chk("m0_led_en", bus.LED_EN, 2'b01);
    chk("m0_dc", bus.DC_Comp, 64);
    chk("m0_pga", bus.PGA_Gain, 15);
    chk("m0_cal_err", bus.Cal_Error, 0);
    chk("m0_drive", bus.LED_DRIVE, 10);

    // Operation: per-LED ADC constants, strobe every SLOT_LEN cycles.
    mode = 1;
    drive_adc();
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 10 : 9) step();
      chk("op_smp_vld", bus.Sample_Valid, 1);
      chk("op_smp_ch", bus.Sample_Ch, k % 2);
      chk("op_smp_data", bus.Sample_Data, (k % 2) ? 200 : 30);
      chk("op_led_en", bus.LED_EN, (k % 2) ? 2'b01 : 2'b10);
      chk("op_dc", bus.DC_Comp, 64);
      chk("op_pga", bus.PGA_Gain, 15);
      step();
      chk("op_smp_vld_low", bus.Sample_Valid, 0);
    end

    // Drop, then restart; drop again inside ch1 PGA search.
    bus.Find_setting = 1'b0;
    step();
    chk("drop_op_valid", bus.Settings_Valid, 0);
    mode = 0;
    drive_adc();
    bus.Find_setting = 1'b1;
    repeat (1000) step();
    chk("pga1_led_en", bus.LED_EN, 2'b10);
    chk("pga1_dc", bus.DC_Comp, 64);
    chk("pga1_gain", bus.PGA_Gain, 3);
    bus.Find_setting = 1'b0;
    step();
    chk("drop_pga_led_en", bus.LED_EN, 0);
    chk("drop_pga_dc", bus.DC_Comp, 0);
    chk("drop_pga_gain", bus.PGA_Gain, 0);
    chk("drop_pga_valid", bus.Settings_Valid, 0);

    // Restart at ch0 with ADC stuck at 0: DC saturates low on both channels.
    bus.Find_setting = 1'b1;
    step();
    chk("restart_led_en", bus.LED_EN, 2'b01);
    chk("restart_dc", bus.DC_Comp, 64);
    chk("restart_pga", bus.PGA_Gain, 0);
    mode = 3;
    drive_adc();
    wait_op(1, 1535);
    chk("zero_cal_err", bus.Cal_Error, 2'b11);
    chk("zero_dc0", bus.DC_Comp, 0);
    chk("zero_pga0", bus.PGA_Gain, 0);

    // Re-calibration clears Cal_Error; AFE model walks DC down and gain up.
    bus.Find_setting = 1'b0;
    step();
    chk("recal_cal_err", bus.Cal_Error, 0);
    chk("recal_led_en", bus.LED_EN, 0);
    mode = 2;
    drive_adc();
    bus.Find_setting = 1'b1;
    wait_op(0, 1709);
    chk("afe_led_en0", bus.LED_EN, 2'b01);
    chk("afe_dc0", bus.DC_Comp, 57);
    chk("afe_pga0", bus.PGA_Gain, 13);
    chk("afe_cal_err", bus.Cal_Error, 0);
    repeat (10) step();
    chk("afe_led_en1", bus.LED_EN, 2'b10);
    chk("afe_dc1", bus.DC_Comp, 57);
    chk("afe_pga1", bus.PGA_Gain, 13);

    // Async reset in the middle of operation.
    mode = 1;
    drive_adc();
    repeat (10) step();
    chk("pre_rst_smp_data", bus.Sample_Data, 200);
    repeat (3) step();
    rst_n = 1'b0;
    #1 chk_reset_outputs("op_rst");
    bus.Find_setting = 1'b0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
